// File: rtl/picorv_mem_pkg.sv
// Shared definitions for the picorv32 native memory bus.
package picorv_mem_pkg;

   localparam int DataWidth    = 32;
   localparam int StrbWidth    = 4;
   localparam int DefaultWords = 256;

   typedef logic [DataWidth-1:0] word_t;
   typedef logic [StrbWidth-1:0] strb_t;

endpackage : picorv_mem_pkg

// File: rtl/ram_1r1w_sync.sv
// Word-organised synchronous RAM with byte write enables and a registered,
// read-first read port. The array is named mem so benches can preload it.
module ram_1r1w_sync
   import picorv_mem_pkg::*;
#(
   parameter int Words = DefaultWords,
   parameter int Width = DataWidth
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     rd_en_i,
   input  logic [Width/8-1:0]       wr_en_i,
   input  logic [$clog2(Words)-1:0] addr_i,
   input  logic [Width-1:0]         wr_data_i,
   output logic [Width-1:0]         rd_data_o
);

   logic [Width-1:0] mem [Words];
   logic [Width-1:0] rd_q;

   // Byte-lane writes into the indexed word.
   // NOTE: storage has no reset branch; clearing a RAM array on reset turns it
   // into flops and prevents block-RAM mapping, and contents must survive reset.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < Width/8; k++) begin
         if (wr_en_i[k]) begin
            mem[addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
         end
      end
   end

   // Registered read; sees the pre-write word on a write access (read-first).
   // NOTE: non-blocking assignments make both blocks sample mem before this
   // edge's write lands, which is exactly the read-first behaviour.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q <= '0;
      end else if (rd_en_i) begin
         rd_q <= mem[addr_i];
      end
   end

   assign rd_data_o = rd_q;

endmodule : ram_1r1w_sync

// File: rtl/picorv32_ram_1r1w_sync.sv
// picorv32 native-bus front end for a synchronous RAM: range decode, request
// gating, one-cycle ready pulse and read-data mux.
// Optional: define RAM_TRACE_EN to print one line per completed transfer.
module picorv32_ram_1r1w_sync
   import picorv_mem_pkg::*;
#(
   parameter int Words = DefaultWords,
   parameter int Width = DataWidth
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 mem_valid_i,
   input  logic                 mem_instr_i,
   input  logic [31:0]          mem_addr_i,
   input  logic [Width-1:0]     mem_wdata_i,
   input  logic [StrbWidth-1:0] mem_wstrb_i,
   output logic                 mem_ready_o,
   output logic [Width-1:0]     mem_rdata_o
);

   localparam int          AddrWidth = $clog2(Words);
   localparam logic [31:0] RamBytes  = 32'(4 * Words);

   logic                 in_ram;
   logic                 en;
   logic [StrbWidth-1:0] wen;
   logic                 ready_q;
   logic                 ready_d;
   logic [Width-1:0]     rd_data;
   logic                 unused_instr;

   // Only used by the trace; keeps the default build free of dangling inputs.
   assign unused_instr = mem_instr_i;

   // Request decode: accept only in-range requests not already being answered.
   // NOTE: every signal here is a continuous assignment, so no path can hold a
   // stale value and no latch can be inferred.
   assign in_ram  = mem_addr_i < RamBytes;
   assign en      = mem_valid_i & ~ready_q & in_ram;
   assign wen     = {StrbWidth{en}} & mem_wstrb_i;
   assign ready_d = en;

   ram_1r1w_sync #(
      .Words (Words),
      .Width (Width)
   ) u_ram (
      .clk_i     (clk_i),
      .rst_i     (reset_i),
      .rd_en_i   (en),
      .wr_en_i   (wen),
      .addr_i    (mem_addr_i[AddrWidth+1:2]),
      .wr_data_i (mem_wdata_i),
      .rd_data_o (rd_data)
   );

   // Ready flop: one-cycle pulse the edge after an accepted request.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= ready_d;
      end
   end

   assign mem_ready_o = ready_q;
   assign mem_rdata_o = in_ram ? rd_data : '0;

`ifdef RAM_TRACE_EN
   // Transfer trace, one line per completed handshake.
   always @(posedge clk_i) begin
      if (mem_valid_i && mem_ready_o) begin
         if (mem_instr_i) begin
            $display("ifetch 0x%08x: 0x%08x", mem_addr_i, mem_rdata_o);
         end else if (mem_wstrb_i != '0) begin
            $display("write  0x%08x: 0x%08x (wstrb=%b)", mem_addr_i, mem_wdata_i, mem_wstrb_i);
         end else begin
            $display("read   0x%08x: 0x%08x", mem_addr_i, mem_rdata_o);
         end
      end
   end
`else
`endif

endmodule : picorv32_ram_1r1w_sync

// File: tb/tb_picorv32_ram_1r1w_sync.sv
// Directed bench for picorv32_ram_1r1w_sync (Words = 256).
module tb_picorv32_ram_1r1w_sync;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        mem_valid_i = 1'b0;
   logic        mem_instr_i = 1'b0;
   logic [31:0] mem_addr_i = '0;
   logic [31:0] mem_wdata_i = '0;
   logic [3:0]  mem_wstrb_i = '0;
   logic        mem_ready_o;
   logic [31:0] mem_rdata_o;

   int checks = 0;
   int errors = 0;

   picorv32_ram_1r1w_sync #(
      .Words (256),
      .Width (32)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .mem_valid_i (mem_valid_i),
      .mem_instr_i (mem_instr_i),
      .mem_addr_i  (mem_addr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_wstrb_i (mem_wstrb_i),
      .mem_ready_o (mem_ready_o),
      .mem_rdata_o (mem_rdata_o)
   );

   always #5 clk_i = ~clk_i;

   // One bus transfer: present at a falling edge, wait (bounded) for ready,
   // capture rdata, drop the request and idle one cycle.
   task automatic bus_xfer(input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic instr,
                           output logic [31:0] rd, output int lat);
      mem_addr_i  = a;
      mem_wdata_i = wd;
      mem_wstrb_i = ws;
      mem_instr_i = instr;
      mem_valid_i = 1'b1;
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!mem_ready_o && lat < 20);
      rd = mem_rdata_o;
      mem_valid_i = 1'b0;
      mem_wstrb_i = '0;
      mem_instr_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      mem_addr_i = 32'h0;
      repeat (100) @(negedge clk_i);
      checks++;
      if (mem_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b want 0", mem_ready_o);
      end
      checks++;
      if (mem_rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %08x want 00000000", mem_rdata_o);
      end
      reset_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_read();
      logic [31:0] rd;
      int lat;
      mem_addr_i  = 32'h0;
      mem_valid_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (mem_ready_o !== 1'b1 || mem_rdata_o !== 32'h3fc00093) begin
         errors++;
         $display("FAIL read_word0: ready %b rdata %08x want 1 3fc00093", mem_ready_o, mem_rdata_o);
      end
      mem_valid_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (mem_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL read_ready_drop: got %b want 0", mem_ready_o);
      end
      bus_xfer(32'h14, 32'h0, 4'b0000, 1'b1, rd, lat);
      checks++;
      if (lat != 1 || rd !== 32'hff5ff06f) begin
         errors++;
         $display("FAIL read_word5: lat %0d rdata %08x want 1 ff5ff06f", lat, rd);
      end
   endtask

   task automatic test_byte_write();
      logic [31:0] rd;
      int lat;
      bus_xfer(32'h3fc, 32'ha5a5a5a5, 4'b0101, 1'b0, rd, lat);
      checks++;
      if (lat != 1 || rd !== 32'h0) begin
         errors++;
         $display("FAIL bytewr_readfirst: lat %0d rdata %08x want 1 00000000", lat, rd);
      end
      bus_xfer(32'h3fc, 32'h0, 4'b0000, 1'b0, rd, lat);
      checks++;
      if (lat != 1 || rd !== 32'h00a500a5) begin
         errors++;
         $display("FAIL bytewr_result: lat %0d rdata %08x want 1 00a500a5", lat, rd);
      end
      // Opposite lanes over the merged word, unaligned address bits ignored.
      bus_xfer(32'h3fe, 32'h12345678, 4'b1010, 1'b0, rd, lat);
      checks++;
      if (rd !== 32'h00a500a5) begin
         errors++;
         $display("FAIL bytewr2_readfirst: rdata %08x want 00a500a5", rd);
      end
      bus_xfer(32'h3fc, 32'h0, 4'b0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 32'h12a556a5) begin
         errors++;
         $display("FAIL bytewr2_result: rdata %08x want 12a556a5", rd);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] rd;
      int lat;
      int seen_ready = 0;
      int bad_rdata = 0;
      mem_addr_i  = 32'h400;
      mem_wdata_i = 32'hffffffff;
      mem_wstrb_i = 4'b1111;
      mem_valid_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (mem_ready_o !== 1'b0) seen_ready++;
         if (mem_rdata_o !== 32'h0) bad_rdata++;
      end
      mem_valid_i = 1'b0;
      mem_wstrb_i = '0;
      checks++;
      if (seen_ready != 0) begin
         errors++;
         $display("FAIL oor_ready: ready seen %0d cycles want 0", seen_ready);
      end
      checks++;
      if (bad_rdata != 0) begin
         errors++;
         $display("FAIL oor_rdata: nonzero rdata %0d cycles want 0", bad_rdata);
      end
      @(negedge clk_i);
      bus_xfer(32'h0, 32'h0, 4'b0000, 1'b0, rd, lat);
      checks++;
      if (rd !== 32'h3fc00093) begin
         errors++;
         $display("FAIL oor_mem_unchanged: word0 %08x want 3fc00093", rd);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int lat;
      mem_addr_i  = 32'h190;
      mem_wdata_i = 32'h11223344;
      mem_wstrb_i = 4'b1111;
      mem_valid_i = 1'b1;
      @(posedge clk_i);
      #2;
      checks++;
      if (mem_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre_ready: got %b want 1", mem_ready_o);
      end
      reset_i = 1'b1;
      #1;
      checks++;
      if (mem_ready_o !== 1'b0 || mem_rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL midrst_cancel: ready %b rdata %08x want 0 00000000", mem_ready_o, mem_rdata_o);
      end
      mem_valid_i = 1'b0;
      mem_wstrb_i = '0;
      @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);
      bus_xfer(32'h190, 32'h0, 4'b0000, 1'b0, rd, lat);
      checks++;
      if (lat != 1 || rd !== 32'h11223344) begin
         errors++;
         $display("FAIL midrst_write_kept: lat %0d rdata %08x want 1 11223344", lat, rd);
      end
   endtask

   // Replays the bus traffic the six-word program issues on a picorv32.
   task automatic test_program();
      logic [31:0] rd;
      int lat;
      int bad = 0;
      bus_xfer(32'h0, 32'h0, 4'b0000, 1'b1, rd, lat);
      if (rd !== 32'h3fc00093) bad++;
      bus_xfer(32'h4, 32'h0, 4'b0000, 1'b1, rd, lat);
      if (rd !== 32'h0000a023) bad++;
      bus_xfer(32'h3fc, 32'h0, 4'b1111, 1'b0, rd, lat);
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL prog_prologue: %0d bad fetches want 0", bad);
      end
      for (int i = 0; i < 4; i++) begin
         bad = 0;
         bus_xfer(32'h8, 32'h0, 4'b0000, 1'b1, rd, lat);
         if (rd !== 32'h0000a103) bad++;
         bus_xfer(32'h3fc, 32'h0, 4'b0000, 1'b0, rd, lat);
         checks++;
         if (lat != 1 || rd !== 32'(i)) begin
            errors++;
            $display("FAIL prog_load_iter%0d: lat %0d rdata %08x want 1 %08x", i, lat, rd, i);
         end
         bus_xfer(32'hc, 32'h0, 4'b0000, 1'b1, rd, lat);
         if (rd !== 32'h00110113) bad++;
         bus_xfer(32'h10, 32'h0, 4'b0000, 1'b1, rd, lat);
         if (rd !== 32'h0020a023) bad++;
         bus_xfer(32'h3fc, 32'(i + 1), 4'b1111, 1'b0, rd, lat);
         bus_xfer(32'h14, 32'h0, 4'b0000, 1'b1, rd, lat);
         if (rd !== 32'hff5ff06f) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL prog_fetch_iter%0d: %0d bad fetches want 0", i, bad);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] seq = '0;
      mem_addr_i  = 32'h4;
      mem_valid_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         seq[i] = mem_ready_o;
      end
      mem_valid_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (seq !== 6'b010101) begin
         errors++;
         $display("FAIL b2b_ready_pattern: got %b want 010101 (lsb first)", seq);
      end
      checks++;
      if (mem_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: ready %b want 0", mem_ready_o);
      end
   endtask

   initial begin
      dut.u_ram.mem[0]   = 32'h3fc00093;
      dut.u_ram.mem[1]   = 32'h0000a023;
      dut.u_ram.mem[2]   = 32'h0000a103;
      dut.u_ram.mem[3]   = 32'h00110113;
      dut.u_ram.mem[4]   = 32'h0020a023;
      dut.u_ram.mem[5]   = 32'hff5ff06f;
      dut.u_ram.mem[100] = 32'h0;
      dut.u_ram.mem[255] = 32'h0;
      test_reset();
      test_read();
      test_byte_write();
      test_out_of_range();
      test_reset_mid();
      test_program();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_picorv32_ram_1r1w_sync
